// File: rtl/seg_display_arbiter_pkg.sv
// Shared types for the seven-segment display arbiter and its blink generator.
package seg_display_arbiter_pkg;

    localparam int SEG_DIGITS = 8;

    typedef logic [4:0] code_t;
    localparam code_t CHAR_BLK = 5'h1F;

    typedef struct packed {
        code_t [SEG_DIGITS-1:0] data;
        logic  [SEG_DIGITS-1:0] on;
        logic  [SEG_DIGITS-1:0] blink;
    } seg_frame_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_MSG
    } seg_arb_state_t;

endpackage

// File: rtl/seg_display_arbiter_blink.sv
// Blink phase generator: phase toggles every HALF_CYC cycles, restart forces phase ON.
// phase_on is the phase that applies from the next edge on, so callers can register it with their data.
module seg_blink_gen #(
    parameter int HALF_CYC = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic phase_on
);

    localparam int CW = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          phase_q;

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        phase_on = phase_q;
        if (restart) begin
            cnt_d    = '0;
            phase_on = 1'b1;
        end else if (cnt_q == LAST) begin
            cnt_d    = '0;
            phase_on = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_on;
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares the 8-digit display between NUM_REQ requesters and a message channel, with hold time and blink.
// Define SEG_ARB_RR_EN for round-robin arbitration; default is fixed priority with index 0 highest.
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int MIN_HOLD_CYC   = 10_000_000,
    parameter int BLINK_HALF_CYC = 25_000_000,
    parameter int MSG_CYC        = 200_000_000
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic  [NUM_REQ-1:0]                    req,
    input  code_t [NUM_REQ-1:0][SEG_DIGITS-1:0]    req_data,
    input  logic  [NUM_REQ-1:0][SEG_DIGITS-1:0]    req_on,
    input  logic  [NUM_REQ-1:0][SEG_DIGITS-1:0]    req_blink,
    input  logic                                   msg_valid,
    input  code_t [SEG_DIGITS-1:0]                 msg_data,
    output logic                                   msg_ready,
    output logic  [NUM_REQ-1:0]                    grant,
    output logic                                   msg_active,
    output code_t [SEG_DIGITS-1:0]                 display_data,
    output logic  [SEG_DIGITS-1:0]                 blink_mask
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HOLD_W = (MIN_HOLD_CYC > 1) ? $clog2(MIN_HOLD_CYC) : 1;
    localparam int MSG_W  = (MSG_CYC > 1) ? $clog2(MSG_CYC) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD_CYC - 1);
    localparam logic [MSG_W-1:0]  MSG_LAST  = MSG_W'(MSG_CYC - 1);

    seg_arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]       owner_q, owner_d, winner;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [MSG_W-1:0]       msg_cnt_q, msg_cnt_d;
    logic [NUM_REQ-1:0]     grant_d;
    code_t [SEG_DIGITS-1:0] display_d;
    logic [SEG_DIGITS-1:0]  mask_d;
    seg_frame_t             sel;
    logic                   accept, challenger, restart, phase_on;

    assign msg_ready  = (state_q != S_MSG);
    assign msg_active = (state_q == S_MSG);
    assign accept     = msg_valid && msg_ready;

`ifdef SEG_ARB_RR_EN
    // owner_q doubles as the rotation pointer: it keeps the last owner through idle and message periods.
    always_comb begin
        logic [IDX_W-1:0] cand;
        winner     = owner_q;
        challenger = 1'b0;
        cand       = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(owner_q) + i) % NUM_REQ);
            if (req[cand]) winner = cand;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (IDX_W'(i) != owner_q)) challenger = 1'b1;
        end
    end
`else
    always_comb begin
        winner     = '0;
        challenger = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) winner = IDX_W'(i);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && (i < int'(owner_q))) challenger = 1'b1;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        msg_cnt_d = msg_cnt_q;
        if (accept) begin
            state_d   = S_MSG;
            msg_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        state_d = S_GRANT;
                        owner_d = winner;
                        hold_d  = '0;
                    end
                end
                S_GRANT: begin
                    // A releasing owner bypasses the hold rule entirely.
                    if (!req[owner_q]) begin
                        if (|req) begin
                            owner_d = winner;
                            hold_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else if (hold_q == HOLD_LAST) begin
                        if (challenger) begin
                            owner_d = winner;
                            hold_d  = '0;
                        end
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_MSG: begin
                    if (msg_cnt_q == MSG_LAST) begin
                        if (|req) begin
                            state_d = S_GRANT;
                            owner_d = winner;
                            hold_d  = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        msg_cnt_d = msg_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        grant_d = '0;
        if (state_d == S_GRANT) grant_d[owner_d] = 1'b1;
    end

    assign restart = accept || (grant_d != grant);

    seg_blink_gen #(
        .HALF_CYC (BLINK_HALF_CYC)
    ) u_blink (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (restart),
        .phase_on (phase_on)
    );

    // The display registers are loaded from whoever owns the display after this edge.
    always_comb begin
        sel.data  = req_data[owner_d];
        sel.on    = req_on[owner_d];
        sel.blink = req_blink[owner_d];
        display_d = display_data;
        mask_d    = blink_mask;
        unique case (state_d)
            S_IDLE: begin
                display_d = {SEG_DIGITS{CHAR_BLK}};
                mask_d    = '0;
            end
            S_GRANT: begin
                display_d = sel.data;
                mask_d    = sel.on & ~(sel.blink & {SEG_DIGITS{~phase_on}});
            end
            S_MSG: begin
                if (accept) display_d = msg_data;
                mask_d = '1;
            end
            default: begin
                display_d = {SEG_DIGITS{CHAR_BLK}};
                mask_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= IDX_W'(NUM_REQ - 1);
            hold_q       <= '0;
            msg_cnt_q    <= '0;
            grant        <= '0;
            display_data <= {SEG_DIGITS{CHAR_BLK}};
            blink_mask   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            hold_q       <= hold_d;
            msg_cnt_q    <= msg_cnt_d;
            grant        <= grant_d;
            display_data <= display_d;
            blink_mask   <= mask_d;
        end
    end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the 8-digit seven-segment display between NUM_REQ status requesters plus one transient message channel.
- Produces registered display_data and blink_mask for seven_seg_display_driver.
- Arbitrates with a minimum hold time to prevent flicker and generates the digit blink phase.
- Sits between the top-level mode FSMs and the display driver.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has highest fixed priority.
- MIN_HOLD_CYC, 10_000_000, minimum ownership cycles before the owner can be preempted by another requester.
- BLINK_HALF_CYC, 25_000_000, cycles per blink half-period.
- MSG_CYC, 200_000_000, cycles a message stays displayed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester display request (level)
- req_data  in  code_t [NUM_REQ-1:0][7:0]  per-requester characters, digit 7 = leftmost
- req_on  in  [NUM_REQ-1:0][7:0]  per-requester digit-enable mask, 1 = lit
- req_blink  in  [NUM_REQ-1:0][7:0]  per-requester blink select, 1 = blinks
- msg_valid  in  1  message offer
- msg_data  in  code_t [7:0]  message characters
- msg_ready  out  1  message accept; high when not in S_MSG
- grant  out  NUM_REQ  one-hot owner, 0 when idle or in a message
- msg_active  out  1  message on display
- display_data  out  code_t [7:0]  to driver
- blink_mask  out  [7:0]  to driver, 1 = lit

Behaviour:
- Reset values:
  - state S_IDLE; grant 0; msg_active 0; msg_ready 1.
  - display_data all CHAR_BLK; blink_mask 0x00.
  - all counters 0; blink phase ON.
- States:
  - S_IDLE: no owner.
  - S_GRANT: owner k.
  - S_MSG: message displayed.
- Message acceptance and S_MSG:
  - Accept = msg_valid & msg_ready. It is evaluated first in every state and always wins over same-cycle request changes.
  - On acceptance: next state S_MSG, msg_data captured, grant cleared, msg_cnt cleared.
  - In S_MSG: msg_ready=0, so offers stall.
  - Display shows captured data with all digits steady lit (blink_mask 0xFF).
  - When msg_cnt reaches MSG_CYC-1: leave S_MSG and re-arbitrate in the same cycle. Next state is S_GRANT if any req is set, else S_IDLE.
- S_IDLE:
  - If any req is set, the winner is granted at the next edge.
  - The display registers are loaded from the winner's inputs at that same edge.
- S_GRANT:
  - Display follows the owner's inputs live with 1-cycle registered latency.
  - hold_cnt increments and saturates at MIN_HOLD_CYC-1.
- Ownership changes in S_GRANT:
  - Owner drops req: released immediately. The hold rule does not apply. Re-arbitrate that cycle; go to S_IDLE if no req.
  - Higher-priority req while hold_cnt < MIN_HOLD_CYC-1: ignored.
  - Higher-priority req once hold_cnt is saturated: switch owner at the next edge and clear hold_cnt.
  - No competing req: owner kept indefinitely.
- Blink generation:
  - A free-running counter toggles phase every BLINK_HALF_CYC cycles.
  - Counter restarts with phase ON on every grant change or message entry.
  - blink_mask = req_on[k] & ~(req_blink[k] & {8{phase==OFF}}).
  - S_IDLE: display all CHAR_BLK, blink_mask 0x00.
- Reset mid-message or mid-grant: immediate abort to reset values.

Optional Feature:
- Macro SEG_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On hold expiry, if any other requester is active, ownership rotates to the first active index after the current owner, wrapping at NUM_REQ.
  - Arbitration from S_IDLE starts the search after the last owner.
- Undefined: fixed priority, index 0 highest; no pointer register is instantiated.

Decomposition:
- project_pkg additions:
  - SEG_DIGITS = 8.
  - seg_frame_t struct {code_t [7:0] data; logic [7:0] on; logic [7:0] blink}.
  - seg_arb_state_t enum {S_IDLE, S_GRANT, S_MSG}.
- Sub-module seg_blink_gen: parameter HALF_CYC; inputs clk, rst_n, restart; output phase_on.

Test Plan (bench params: MIN_HOLD_CYC=8, BLINK_HALF_CYC=4, MSG_CYC=20, NUM_REQ=4):
- Reset then req=4'b0100, req_data[2]="12345678", req_on[2]=0xFF, req_blink[2]=0 -> next edge grant=0100; display_data="12345678"; blink_mask=0xFF steady.
- Owner req[2] held, req[0] asserted at hold_cnt=3 -> grant stays 0100 until hold_cnt=7, then grant=0001 one edge later.
- Owner drops req at hold_cnt=2 with req[3] pending -> grant=1000 next edge; with no pending req -> S_IDLE, display all CHAR_BLK, blink_mask=0x00.
- req_blink[k]=0x0F, req_on=0xFF -> blink_mask alternates 0xFF/0xF0 every 4 cycles; phase restarts ON at a grant change.
- msg_valid during S_GRANT -> accepted same cycle; msg_active=1 for 20 cycles; blink_mask=0xFF; second msg_valid stalls (msg_ready=0) until exit; then prior requester is re-granted.
- SEG_ARB_RR_EN defined, req=4'b1111 held -> grant sequence 0001, 0010, 0100, 1000, 0001, each held 8 cycles.
